spram_arbiter: RTL and testbench

Shares one `single_port_pemory` instance between two requesters with valid/ready handshakes. It picks at most one request per cycle with round-robin fairness, drives the memory port, and returns read data to the requester that issued the read, one cycle after grant. It sits between two client blocks (e.g. a CPU-side register port and a DMA engine) and the memory.

---
 rtl/spram_arb_pkg.sv | 18 +
 rtl/rr_arbiter_2.sv | 37 +++
 rtl/spram_arbiter.sv | 74 +++++++
 tb/tb_spram_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// rtl/spram_arb_pkg.sv - shared types and reset constants for the single-port RAM arbiter
package spram_arb_pkg;

   localparam int NUM_PORTS = 2;

   typedef logic [0:0] port_idx_t;

   // Port 1 counts as last granted after reset, so port 0 wins the first contention
   localparam port_idx_t LAST_GRANT_RESET = 1'b1;

   function automatic logic [NUM_PORTS-1:0] idx_to_onehot(input port_idx_t idx);
      logic [NUM_PORTS-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant logic with the last_grant pointer
module rr_arbiter_2
   import spram_arb_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 accept,
   output logic [NUM_PORTS-1:0] grant,
   output port_idx_t            grant_idx
);

   port_idx_t last_grant;

   always_comb begin
      grant_idx = ~last_grant;
      grant     = '0;
      if (!reset) begin
         case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            default: grant_idx = ~last_grant;
         endcase
         if (|req) grant = idx_to_onehot(grant_idx);
      end
   end

   // Pointer only moves on an accepted request; idle cycles keep the priority
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= LAST_GRANT_RESET;
      end else if (accept) begin
         last_grant <= grant_idx;
      end
   end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-requester arbiter for a single-port RAM; SPRAM_ARB_WRITE_ACK_EN adds write responses
module spram_arbiter
   import spram_arb_pkg::*;
#(
   parameter int DATAWIDTH    = 8,
   parameter int DATADEPTH    = 1024,
   parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_PORTS-1:0]                  req_valid,
   output logic [NUM_PORTS-1:0]                  req_ready,
   input  logic [NUM_PORTS-1:0]                  req_write,
   input  logic [NUM_PORTS-1:0][ADDRESSWIDTH-1:0] req_addr,
   input  logic [NUM_PORTS-1:0][DATAWIDTH-1:0]    req_wdata,
   output logic [NUM_PORTS-1:0]                  rsp_valid,
   output logic [DATAWIDTH-1:0]                  rsp_rdata,
   output logic                                  mem_write_en,
   output logic [ADDRESSWIDTH-1:0]               mem_address,
   output logic [DATAWIDTH-1:0]                  mem_data_in,
   input  logic [DATAWIDTH-1:0]                  mem_data_out
);

   logic [NUM_PORTS-1:0]    grant;
   port_idx_t               grant_idx;
   logic                    accept;
   logic                    rsp_fire;
   logic [ADDRESSWIDTH-1:0] addr_hold;
   logic                    rsp_pending;
   port_idx_t               rsp_owner;
   logic [DATAWIDTH-1:0]    rdata_hold;

   rr_arbiter_2 u_rr (
      .clk       (clk),
      .reset     (reset),
      .req       (req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign accept    = |(req_valid & grant);

   // Address falls back to the hold register so the RAM output stays stable while idle
   assign mem_address  = accept ? req_addr[grant_idx] : addr_hold;
   assign mem_data_in  = req_wdata[grant_idx];
   assign mem_write_en = accept & req_write[grant_idx];

`ifdef SPRAM_ARB_WRITE_ACK_EN
   assign rsp_fire = accept;
`else
   assign rsp_fire = accept & ~req_write[grant_idx];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_hold   <= '0;
         rsp_pending <= 1'b0;
         rsp_owner   <= '0;
         rdata_hold  <= '0;
      end else begin
         if (accept) addr_hold <= req_addr[grant_idx];
         rsp_pending <= rsp_fire;
         if (rsp_fire) rsp_owner <= grant_idx;
         if (|rsp_valid) rdata_hold <= mem_data_out;
      end
   end

   // A response due in a reset cycle is dropped rather than delivered
   assign rsp_valid = (rsp_pending && !reset) ? idx_to_onehot(rsp_owner) : '0;
   assign rsp_rdata = (|rsp_valid) ? mem_data_out : rdata_hold;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - directed and random checks of spram_arbiter against a behavioural model
module tb_spram_arbiter;

`ifdef SPRAM_ARB_WRITE_ACK_EN
   localparam bit WACK = 1'b1;
`else
   localparam bit WACK = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_ready;
   logic [1:0]      req_write = '0;
   logic [1:0][9:0] req_addr = '0;
   logic [1:0][7:0] req_wdata = '0;
   logic [1:0]      rsp_valid;
   logic [7:0]      rsp_rdata;
   logic            mem_write_en;
   logic [9:0]      mem_address;
   logic [7:0]      mem_data_in;
   logic [7:0]      mem_data_out;

   always #5 clk = ~clk;

   spram_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .mem_write_en (mem_write_en),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   // Synchronous single-port RAM, write-first on read-during-write
   logic [7:0] mem_array [1024];
   always @(posedge clk) begin
      if (mem_write_en) mem_array[mem_address] <= mem_data_in;
      mem_data_out <= mem_write_en ? mem_data_in : mem_array[mem_address];
   end

   // Reference model state
   int         n_cmp = 0;
   int         n_err = 0;
   int         m_last;
   int         m_hold_addr;
   logic [1:0] m_rv;
   logic [7:0] m_rd;
   logic [7:0] ref_mem [1024];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last      = 1;
      m_hold_addr = 0;
      m_rv        = '0;
      m_rd        = '0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 2'b11;
      req_write = 2'b00;
      #1;
      chk("ready_in_reset", req_ready, 2'b00);
      chk("rsp_valid_in_reset", rsp_valid, 2'b00);
      chk("wen_in_reset", mem_write_en, 1'b0);
      @(posedge clk);
      @(negedge clk);
      reset     = 1'b0;
      req_valid = '0;
      model_reset();
   endtask

   // Drive one cycle at the negedge, check against the model, advance to the next negedge
   task automatic step(input logic [1:0] v, input logic [1:0] w, input int a0, input int a1,
                       input int d0, input int d1, output int g);
      int a[2];
      int d[2];
      logic [1:0] nrv;
      logic [7:0] nrd;
      a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
      req_valid = v;
      req_write = w;
      req_addr[0] = 10'(a0); req_addr[1] = 10'(a1);
      req_wdata[0] = 8'(d0); req_wdata[1] = 8'(d1);
      g = -1;
      if (v == 2'b01) g = 0;
      else if (v == 2'b10) g = 1;
      else if (v == 2'b11) g = 1 - m_last;
      #1;
      chk("req_ready", req_ready, (g < 0) ? 2'b00 : (2'b01 << g));
      chk("mem_write_en", mem_write_en, (g >= 0) ? w[g] : 1'b0);
      chk("mem_address", mem_address, (g >= 0) ? a[g] : m_hold_addr);
      if (g >= 0 && w[g]) chk("mem_data_in", mem_data_in, d[g] & 8'hff);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("rsp_rdata", rsp_rdata, m_rd);
      nrv = '0;
      nrd = m_rd;
      if (g >= 0) begin
         m_last = g;
         m_hold_addr = a[g];
         if (w[g]) begin
            ref_mem[a[g]] = 8'(d[g]);
            if (WACK) begin
               nrv = 2'b01 << g;
               nrd = 8'(d[g]);
            end
         end else begin
            nrv = 2'b01 << g;
            nrd = ref_mem[a[g]];
         end
      end
      m_rv = nrv;
      m_rd = nrd;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int g;
      int seq[4];
      for (int i = 0; i < 1024; i++) begin
         mem_array[i] = '0;
         ref_mem[i]   = '0;
      end
      mem_data_out = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Reset state and single read after reset
      step(2'b00, 2'b00, 0, 0, 0, 0, g);
      chk("reset_addr", mem_address, 10'd0);
      step(2'b01, 2'b01, 3, 0, 8'hA5, 0, g);
      step(2'b10, 2'b00, 0, 3, 0, 0, g);
      chk("tp1_rsp_valid", rsp_valid, 2'b10);
      chk("tp1_rsp_rdata", rsp_rdata, 8'hA5);
      step(2'b00, 2'b00, 0, 0, 0, 0, g);

      // Continuous contention; last preload from port 1 leaves port 0 first
      step(2'b01, 2'b01, 10, 0, 8'h11, 0, g);
      step(2'b10, 2'b10, 0, 20, 0, 8'h22, g);
      for (int i = 0; i < 4; i++) begin
         step(2'b11, 2'b00, 10, 20, 0, 0, g);
         seq[i] = g;
         chk("cont_rdata", rsp_rdata, (i % 2 == 0) ? 8'h11 : 8'h22);
      end
      chk("cont_grants", {seq[0][1:0], seq[1][1:0], seq[2][1:0], seq[3][1:0]}, 8'b00_01_00_01);
      step(2'b00, 2'b00, 0, 0, 0, 0, g);

      // Idle pointer hold
      step(2'b10, 2'b00, 0, 10, 0, 0, g);
      for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 0, 0, 0, 0, g);
      step(2'b11, 2'b00, 20, 10, 0, 0, g);
      chk("idle_hold_grant", g, 0);

      // Write then read same address
      step(2'b01, 2'b01, 5, 0, 8'h7E, 0, g);
      chk("wr_ack_valid", rsp_valid, WACK ? 2'b01 : 2'b00);
      step(2'b10, 2'b00, 0, 5, 0, 0, g);
      chk("raw_rdata", rsp_rdata, 8'h7E);

      // Reset while a read response is pending
      step(2'b10, 2'b00, 0, 3, 0, 0, g);
      do_reset();
      step(2'b00, 2'b00, 0, 0, 0, 0, g);
      chk("post_reset_rsp", rsp_valid, 2'b00);
      step(2'b11, 2'b00, 3, 5, 0, 0, g);
      chk("post_reset_grant", g, 0);
      chk("mem_preserved", rsp_rdata, 8'hA5);
      step(2'b00, 2'b00, 0, 0, 0, 0, g);

      // Random traffic, occasional reset
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         step(2'($urandom), 2'($urandom), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 255), $urandom_range(0, 255), g);
      end
      step(2'b00, 2'b00, 0, 0, 0, 0, g);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
